// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrdemux4_pkg.sv
// Shared lane-index types and helpers for the round-robin 1-to-4 stream demux.
package gf180mcu_fd_sc_mcu9t5v0__rrdemux4_pkg;

  localparam int NUM_LANES = 4;
  localparam int PTR_W     = 2;
  localparam int SCNT_W    = 8;

  typedef logic [PTR_W-1:0] lane_t;

  function automatic logic [NUM_LANES-1:0] onehot4(input lane_t lane);
    logic [NUM_LANES-1:0] oh;
    oh = '0;
    oh[lane] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrdemux4_ptr.sv
// Round-robin lane pointer: advances by one (wrapping 3 -> 0) on adv, exports one-hot lane select.
module gf180mcu_fd_sc_mcu9t5v0__rrdemux4_ptr
  import gf180mcu_fd_sc_mcu9t5v0__rrdemux4_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adv,
  output lane_t                ptr,
  output logic [NUM_LANES-1:0] lane_oh
);

  lane_t ptr_reg;
  lane_t ptr_next;

  always_comb begin
    ptr_next = ptr_reg;
    if (adv) begin
      ptr_next = ptr_reg + lane_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr     = ptr_reg;
  assign lane_oh = onehot4(ptr_reg);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrdemux4_1.sv
// One-entry valid/ready fan-out to four lanes in strict round-robin order.
// Optional stalled-lane skipping is enabled by defining GF180MCU_FD_SC_MCU9T5V0_RRDEMUX4_SKIP_EN.
module gf180mcu_fd_sc_mcu9t5v0__rrdemux4_1
  import gf180mcu_fd_sc_mcu9t5v0__rrdemux4_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STALL_MAX = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     I,
  input  logic                 I_VLD,
  output logic                 I_RDY,
  output logic [WIDTH-1:0]     Z,
  output logic [NUM_LANES-1:0] Z_VLD,
  input  logic [NUM_LANES-1:0] Z_RDY
);

  logic                 full_reg;
  logic                 full_next;
  logic [WIDTH-1:0]     data_reg;
  logic [WIDTH-1:0]     data_next;
  lane_t                ptr;
  logic [NUM_LANES-1:0] lane_oh;
  logic [NUM_LANES-1:0] lane_rdy_hit;
  logic                 sel_rdy;
  logic                 fire;
  logic                 accept;
  logic                 skip;
  logic                 adv;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi = gi + 1) begin : g_lane
      assign Z_VLD[gi]        = full_reg & lane_oh[gi];
      assign lane_rdy_hit[gi] = lane_oh[gi] & Z_RDY[gi];
    end
  endgenerate

  assign sel_rdy = |lane_rdy_hit;
  assign fire    = full_reg & sel_rdy;
  // Ready looks through to the current lane so a word can leave and enter in one cycle.
  assign I_RDY   = ~RST & (~full_reg | fire);
  assign accept  = I_VLD & I_RDY;
  assign adv     = fire | skip;
  assign Z       = data_reg;

`ifdef GF180MCU_FD_SC_MCU9T5V0_RRDEMUX4_SKIP_EN
  logic [SCNT_W-1:0] scnt_reg;
  logic [SCNT_W-1:0] scnt_next;

  assign skip = full_reg & ~sel_rdy & (scnt_reg == SCNT_W'(STALL_MAX - 1));

  always_comb begin
    scnt_next = scnt_reg;
    if (adv) begin
      scnt_next = '0;
    end else if (full_reg & ~sel_rdy) begin
      scnt_next = scnt_reg + SCNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scnt_reg <= '0;
    end else begin
      scnt_reg <= scnt_next;
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    full_next = full_reg;
    data_next = data_reg;
    if (fire) begin
      full_next = 1'b0;
    end
    if (accept) begin
      full_next = 1'b1;
      data_next = I;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else begin
      full_reg <= full_next;
      data_reg <= data_next;
    end
  end

  gf180mcu_fd_sc_mcu9t5v0__rrdemux4_ptr u_ptr (
    .clk     (CLK),
    .rst     (RST),
    .adv     (adv),
    .ptr     (ptr),
    .lane_oh (lane_oh)
  );

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rrdemux4_1.sv
// Directed self-checking bench for the round-robin 1-to-4 demux (WIDTH=8, STALL_MAX=3).
module tb_gf180mcu_fd_sc_mcu9t5v0__rrdemux4_1;

  logic       CLK;
  logic       RST;
  logic [7:0] I;
  logic       I_VLD;
  logic       I_RDY;
  logic [7:0] Z;
  logic [3:0] Z_VLD;
  logic [3:0] Z_RDY;

  int n_checks = 0;
  int n_fail   = 0;

  gf180mcu_fd_sc_mcu9t5v0__rrdemux4_1 #(
    .WIDTH     (8),
    .STALL_MAX (3)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .I     (I),
    .I_VLD (I_VLD),
    .I_RDY (I_RDY),
    .Z     (Z),
    .Z_VLD (Z_VLD),
    .Z_RDY (Z_RDY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
    $display("check %-14s observed=%02h expected=%02h", tag, obs, exp);
  endtask

  task automatic do_reset();
    I_VLD = 1'b0;
    I     = 8'h00;
    Z_RDY = 4'b0000;
    RST   = 1'b1;
    tick();
    RST   = 1'b0;
    #1;
  endtask

  initial begin
    RST   = 1'b1;
    I     = 8'h00;
    I_VLD = 1'b0;
    Z_RDY = 4'b0000;
    #3;
    // 1. reset values and first word latency
    chk("rst_zvld", {4'b0, Z_VLD}, 8'h00);
    chk("rst_irdy", {7'b0, I_RDY}, 8'h00);
    chk("rst_z", Z, 8'h00);
    tick();
    RST = 1'b0;
    I = 8'h11; I_VLD = 1'b1;
    #1;
    chk("first_irdy", {7'b0, I_RDY}, 8'h01);
    tick();
    I_VLD = 1'b0;
    #1;
    chk("first_zvld", {4'b0, Z_VLD}, 8'h01);
    chk("first_z", Z, 8'h11);
    chk("first_full", {7'b0, I_RDY}, 8'h00);

    // 2. streaming, all lanes ready
    do_reset();
    Z_RDY = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      I = 8'hA1 + 8'(k); I_VLD = 1'b1;
      #1;
      chk("strm_irdy", {7'b0, I_RDY}, 8'h01);
      tick();
      chk("strm_zvld", {4'b0, Z_VLD}, 8'h01 << (k % 4));
      chk("strm_z", Z, 8'hA1 + 8'(k));
    end
    I_VLD = 1'b0;
    tick();
    chk("strm_drain", {4'b0, Z_VLD}, 8'h00);

    // 3. backpressure then simultaneous fire and accept
    do_reset();
    I = 8'h55; I_VLD = 1'b1;
    tick();
    I = 8'h66;
    #1;
    chk("bp_zvld", {4'b0, Z_VLD}, 8'h01);
    chk("bp_z", Z, 8'h55);
    chk("bp_irdy", {7'b0, I_RDY}, 8'h00);
    tick();
    chk("bp_hold_z", Z, 8'h55);
    chk("bp_hold_zvld", {4'b0, Z_VLD}, 8'h01);
    Z_RDY = 4'b0001;
    #1;
    chk("bp_pass_irdy", {7'b0, I_RDY}, 8'h01);
    tick();
    Z_RDY = 4'b0000; I_VLD = 1'b0;
    #1;
    chk("bp_next_zvld", {4'b0, Z_VLD}, 8'h02);
    chk("bp_next_z", Z, 8'h66);

    // 4/5. lane 0 stalled
    do_reset();
    Z_RDY = 4'b1110;
    I = 8'h77; I_VLD = 1'b1;
    tick();
    I_VLD = 1'b0;
    #1;
`ifdef GF180MCU_FD_SC_MCU9T5V0_RRDEMUX4_SKIP_EN
    for (int c = 0; c < 3; c++) begin
      chk("skip_wait_zvld", {4'b0, Z_VLD}, 8'h01);
      chk("skip_wait_z", Z, 8'h77);
      tick();
    end
    chk("skip_zvld", {4'b0, Z_VLD}, 8'h02);
    chk("skip_z", Z, 8'h77);
    chk("skip_fire", {7'b0, I_RDY}, 8'h01);
    tick();
    chk("skip_empty", {4'b0, Z_VLD}, 8'h00);
    Z_RDY = 4'b0000;
    I = 8'h78; I_VLD = 1'b1;
    tick();
    I_VLD = 1'b0;
    #1;
    chk("skip_ptr2", {4'b0, Z_VLD}, 8'h04);
`else
    for (int c = 0; c < 20; c++) begin
      chk("hold_zvld", {4'b0, Z_VLD}, 8'h01);
      chk("hold_z", Z, 8'h77);
      chk("hold_irdy", {7'b0, I_RDY}, 8'h00);
      tick();
    end
`endif

    // 6. reset while holding a word on lane 2
    do_reset();
    Z_RDY = 4'b1111;
    I = 8'h01; I_VLD = 1'b1;
    tick();
    I = 8'h02;
    tick();
    I = 8'h99;
    tick();
    Z_RDY = 4'b0000; I_VLD = 1'b0;
    #1;
    chk("mid_zvld", {4'b0, Z_VLD}, 8'h04);
    chk("mid_z", Z, 8'h99);
    RST = 1'b1;
    #1;
    chk("mid_rst_zvld", {4'b0, Z_VLD}, 8'h00);
    chk("mid_rst_irdy", {7'b0, I_RDY}, 8'h00);
    chk("mid_rst_z", Z, 8'h00);
    tick();
    RST = 1'b0;
    I = 8'h10; I_VLD = 1'b1;
    tick();
    I_VLD = 1'b0;
    #1;
    chk("post_rst_zvld", {4'b0, Z_VLD}, 8'h01);
    chk("post_rst_z", Z, 8'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
